while_loop_ctrl: RTL and testbench

//   Hardware pre-test loop sequencer: the counterpart of a post-test (do-while) loop.
//   It tests the condition before every body, so it runs zero or more iterations.
//   It drives an external body unit through a start/done handshake and exposes the

---
 rtl/while_loop_ctrl_pkg.sv | 19 +
 rtl/while_loop_ctrl_if.sv | 35 +++
 rtl/while_loop_ctrl_iter.sv | 50 +++++
 rtl/while_loop_ctrl.sv | 114 +++++++++++
 tb/tb_while_loop_ctrl.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/while_loop_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : loop_ctrl_pkg
//  Brief    : Shared types for the pre-test loop sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package loop_ctrl_pkg;

  // Controller phases: condition test precedes every body execution.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    TEST   = 3'd1,
    BODY   = 3'd2,
    WAIT   = 3'd3,
    FINISH = 3'd4
  } loop_state_e;

endpackage
`default_nettype wire

// File: rtl/while_loop_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : while_loop_ctrl_if
//  Brief    : Sequencing-master and body-unit signals of the loop controller.
//  Revision : 1.0 - initial release
// ============================================================================
interface while_loop_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             start_i;
  logic             ready_o;
  logic [CNT_W-1:0] init_i;
  logic [CNT_W-1:0] limit_i;
  logic             body_start_o;
  logic             body_done_i;
  logic [CNT_W-1:0] body_data_i;
  logic [CNT_W-1:0] local_o;
  logic [CNT_W-1:0] iter_o;
  logic [CNT_W-1:0] temp_o;
  logic             busy_o;
  logic             done_o;

  // Controller side
  modport slave (
    input  start_i, init_i, limit_i, body_done_i, body_data_i,
    output ready_o, body_start_o, local_o, iter_o, temp_o, busy_o, done_o
  );

  // Environment side (sequencing master plus body unit)
  modport master (
    output start_i, init_i, limit_i, body_done_i, body_data_i,
    input  ready_o, body_start_o, local_o, iter_o, temp_o, busy_o, done_o
  );
endinterface
`default_nettype wire

// File: rtl/while_loop_ctrl_iter.sv
`default_nettype none
// ============================================================================
//  Module   : loop_iter_counter
//  Brief    : Loop variable y with saturating step and overflow flag; reports
//             whether the loop condition (y < lim) still holds.
//  Revision : 1.0 - initial release
// ============================================================================
module loop_iter_counter #(
  parameter int CNT_W = 8,
  parameter int STEP  = 1
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_load,
  input  wire logic [CNT_W-1:0] i_load_val,
  input  wire logic             i_step,
  input  wire logic [CNT_W-1:0] i_lim,
  output logic                  o_lt
);

  localparam logic [CNT_W:0] c_step = (CNT_W+1)'(STEP);

  logic [CNT_W-1:0] r_y;
  logic             r_ovf;
  logic [CNT_W:0]   w_sum;

  // One extra bit catches the carry so y never wraps back below the limit.
  assign w_sum = {1'b0, r_y} + c_step;

  // Load on accepted start, advance after each completed body.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_y   <= '0;
      r_ovf <= 1'b0;
    end else if (i_load) begin
      r_y   <= i_load_val;
      r_ovf <= 1'b0;
    end else if (i_step) begin
      if (w_sum[CNT_W]) begin
        r_ovf <= 1'b1;
      end else begin
        r_y <= w_sum[CNT_W-1:0];
      end
    end
  end

  assign o_lt = (r_y < i_lim) && !r_ovf;

endmodule
`default_nettype wire

// File: rtl/while_loop_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : while_loop_ctrl
//  Brief    : Pre-test (while) loop sequencer driving an external body unit
//             through a start/done handshake. Loop-local and outer-scope
//             results are kept in separate registers.
//  Revision : 1.0 - initial release
// ============================================================================
module while_loop_ctrl
  import loop_ctrl_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int STEP      = 1,
  parameter int OUTER_VAL = 1
) (
  input  wire logic       clk,
  input  wire logic       rst,
  while_loop_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] c_outer_val = CNT_W'(OUTER_VAL);
  localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);

  loop_state_e      r_state;
  logic [CNT_W-1:0] r_lim;
  logic [CNT_W-1:0] r_local;
  logic [CNT_W-1:0] r_iter;
  logic [CNT_W-1:0] r_temp;
  logic             r_body_start;
  logic             r_done;

  logic             w_load;
  logic             w_step;
  logic             w_lt;

  assign w_load = (r_state == IDLE) && bus.start_i;
  assign w_step = (r_state == WAIT) && bus.body_done_i;

  loop_iter_counter #(
    .CNT_W (CNT_W),
    .STEP  (STEP)
  ) u_iter (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (bus.init_i),
    .i_step     (w_step),
    .i_lim      (r_lim),
    .o_lt       (w_lt)
  );

  // Loop sequencer; pulse outputs are registered on entry to their state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_lim        <= '0;
      r_local      <= '0;
      r_iter       <= '0;
      r_temp       <= '0;
      r_body_start <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_body_start <= 1'b0;
      r_done       <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start_i) begin
            r_lim   <= bus.limit_i;
            r_iter  <= '0;
            r_local <= '0;
            r_state <= TEST;
          end
        end
        TEST: begin
          if (w_lt) begin
            r_body_start <= 1'b1;
            r_state      <= BODY;
          end else begin
            r_done  <= 1'b1;
            r_state <= FINISH;
          end
        end
        BODY: begin
          r_state <= WAIT;
        end
        WAIT: begin
          if (bus.body_done_i) begin
            r_local <= bus.body_data_i;
            r_iter  <= r_iter + c_one;
            r_state <= TEST;
          end
        end
        FINISH: begin
          // Outer scope only ever sees the constant, never body data.
          r_temp  <= c_outer_val;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready_o      = (r_state == IDLE);
  assign bus.busy_o       = (r_state != IDLE);
  assign bus.body_start_o = r_body_start;
  assign bus.done_o       = r_done;
  assign bus.local_o      = r_local;
  assign bus.iter_o       = r_iter;
  assign bus.temp_o       = r_temp;

endmodule
`default_nettype wire

// File: tb/tb_while_loop_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_while_loop_ctrl
//  Brief    : Self-checking bench for while_loop_ctrl (STEP=1 and STEP=2).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_while_loop_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  while_loop_ctrl_if #(.CNT_W(8)) u_if1 ();
  while_loop_ctrl_if #(.CNT_W(8)) u_if2 ();

  while_loop_ctrl #(.CNT_W(8), .STEP(1), .OUTER_VAL(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (u_if1)
  );

  while_loop_ctrl #(.CNT_W(8), .STEP(2), .OUTER_VAL(1)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (u_if2)
  );

  // Reference: number of bodies a while loop executes, y never wraps.
  function automatic int model_iters(int init, int lim, int step, int w);
    int     n = 0;
    longint y = init;
    while (y < lim) begin
      n++;
      y += step;
      if (y >= (longint'(1) << w)) break;
    end
    return n;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    u_if1.start_i = 1'b0; u_if1.init_i = '0; u_if1.limit_i = '0;
    u_if1.body_done_i = 1'b0; u_if1.body_data_i = '0;
    u_if2.start_i = 1'b0; u_if2.init_i = '0; u_if2.limit_i = '0;
    u_if2.body_done_i = 1'b0; u_if2.body_data_i = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Drives one loop on DUT1 and acts as body unit. Returns at the negedge of
  // the done_o cycle; cycle 0 is the cycle in which start_i is presented.
  task automatic run1(input logic [7:0] init, input logic [7:0] lim, input int maxd,
                      input bit fixed, input logic [7:0] fdata, input bit noise,
                      output int done_cyc, output int pulses, output int sum_d,
                      output logic [7:0] last_data, output bit timeout);
    int         cnt;
    logic [7:0] d8;
    done_cyc = -1; pulses = 0; sum_d = 0; last_data = '0; timeout = 1'b1; cnt = 0;
    u_if1.init_i = init; u_if1.limit_i = lim; u_if1.start_i = 1'b1;
    u_if1.body_done_i = 1'b0;
    for (int c = 1; c <= 2000; c++) begin
      @(negedge clk);
      u_if1.start_i = noise;
      if (noise) begin
        u_if1.init_i  = 8'($urandom);
        u_if1.limit_i = 8'($urandom);
      end
      u_if1.body_done_i = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          d8 = fixed ? fdata : 8'($urandom);
          u_if1.body_data_i = d8;
          u_if1.body_done_i = 1'b1;
          last_data = d8;
        end
      end
      if (u_if1.body_start_o) begin
        pulses++;
        cnt = $urandom_range(maxd, 1);
        sum_d += cnt;
        if (noise) begin
          u_if1.body_done_i = 1'b1;
          u_if1.body_data_i = 8'h55;
        end
      end
      if (u_if1.done_o) begin
        done_cyc = c;
        timeout  = 1'b0;
        u_if1.start_i = 1'b0;
        u_if1.body_done_i = 1'b0;
        break;
      end
    end
    u_if1.start_i = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (u_if1.ready_o !== 1'b1 || u_if1.busy_o !== 1'b0) begin
      errors++; $display("FAIL reset_ready: ready=%b busy=%b want 1/0", u_if1.ready_o, u_if1.busy_o);
    end
    checks++;
    if ({u_if1.local_o, u_if1.iter_o, u_if1.temp_o} !== 24'h0 ||
        u_if1.done_o !== 1'b0 || u_if1.body_start_o !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: local=%h iter=%h temp=%h done=%b bs=%b want zeros",
                         u_if1.local_o, u_if1.iter_o, u_if1.temp_o, u_if1.done_o, u_if1.body_start_o);
    end
    checks++;
    if (u_if2.ready_o !== 1'b1 || u_if2.temp_o !== 8'h0) begin
      errors++; $display("FAIL reset_dut2: ready=%b temp=%h want 1/00", u_if2.ready_o, u_if2.temp_o);
    end
  endtask

  task automatic test_count();
    int dc, p, sd, n; logic [7:0] ld; bit to;
    n = model_iters(0, 5, 1, 8);
    run1(8'd0, 8'd5, 1, 1'b0, 8'h00, 1'b0, dc, p, sd, ld, to);
    checks++;
    if (to || p != n || dc != 17) begin
      errors++; $display("FAIL count_basic: pulses=%0d done_at=%0d timeout=%0b want %0d/17", p, dc, to, n);
    end
    checks++;
    if (u_if1.iter_o !== 8'(n)) begin
      errors++; $display("FAIL count_iter: iter=%0d want %0d", u_if1.iter_o, n);
    end
    @(negedge clk);
    checks++;
    if (u_if1.done_o !== 1'b0 || u_if1.temp_o !== 8'd1 || u_if1.ready_o !== 1'b1 || u_if1.local_o !== ld) begin
      errors++; $display("FAIL count_after: done=%b temp=%h ready=%b local=%h want 0/01/1/%h",
                         u_if1.done_o, u_if1.temp_o, u_if1.ready_o, u_if1.local_o, ld);
    end
  endtask

  task automatic test_zero_iter();
    int dc, p, sd; logic [7:0] ld; bit to;
    run1(8'd7, 8'd5, 1, 1'b0, 8'h00, 1'b0, dc, p, sd, ld, to);
    checks++;
    if (to || p != 0 || dc != 2 || u_if1.iter_o !== 8'd0) begin
      errors++; $display("FAIL zero_iter: pulses=%0d done_at=%0d iter=%0d want 0/2/0", p, dc, u_if1.iter_o);
    end
    @(negedge clk);
    checks++;
    if (u_if1.temp_o !== 8'd1 || u_if1.local_o !== 8'd0) begin
      errors++; $display("FAIL zero_iter_regs: temp=%h local=%h want 01/00", u_if1.temp_o, u_if1.local_o);
    end
  endtask

  task automatic test_scope();
    int dc, p, sd; logic [7:0] ld; bit to;
    apply_reset();
    run1(8'd0, 8'd1, 1, 1'b1, 8'hAA, 1'b0, dc, p, sd, ld, to);
    checks++;
    if (to || p != 1 || u_if1.local_o !== 8'hAA || u_if1.iter_o !== 8'd1) begin
      errors++; $display("FAIL scope_local: pulses=%0d local=%h iter=%0d want 1/aa/1", p, u_if1.local_o, u_if1.iter_o);
    end
    @(negedge clk);
    checks++;
    if (u_if1.temp_o !== 8'd1 || u_if1.local_o !== 8'hAA) begin
      errors++; $display("FAIL scope_outer: temp=%h local=%h want 01/aa", u_if1.temp_o, u_if1.local_o);
    end
  endtask

  task automatic test_overflow();
    int n, p, dc; bit pend;
    n = model_iters(254, 255, 2, 8);
    p = 0; dc = -1; pend = 1'b0;
    @(negedge clk);
    u_if2.init_i = 8'd254; u_if2.limit_i = 8'd255; u_if2.start_i = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      u_if2.start_i = 1'b0;
      u_if2.body_done_i = pend;
      u_if2.body_data_i = 8'h3C;
      pend = 1'b0;
      if (u_if2.body_start_o) begin p++; pend = 1'b1; end
      if (u_if2.done_o) begin dc = c; break; end
    end
    u_if2.body_done_i = 1'b0;
    checks++;
    if (dc != 2 + 3 * n || p != n || u_if2.iter_o !== 8'(n)) begin
      errors++; $display("FAIL overflow_exit: done_at=%0d pulses=%0d iter=%0d want %0d/%0d/%0d",
                         dc, p, u_if2.iter_o, 2 + 3 * n, n, n);
    end
  endtask

  task automatic test_reset_mid();
    bit seen, bad;
    seen = 1'b0; bad = 1'b0;
    @(negedge clk);
    u_if1.init_i = 8'd0; u_if1.limit_i = 8'd3; u_if1.start_i = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      u_if1.start_i = 1'b0;
      if (u_if1.body_start_o) begin seen = 1'b1; break; end
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (!seen || u_if1.ready_o !== 1'b1 || u_if1.busy_o !== 1'b0 || u_if1.done_o !== 1'b0 ||
        {u_if1.local_o, u_if1.iter_o, u_if1.temp_o} !== 24'h0) begin
      errors++; $display("FAIL reset_mid: seen=%b ready=%b done=%b local=%h iter=%h temp=%h want 1/1/0/0/0/0",
                         seen, u_if1.ready_o, u_if1.done_o, u_if1.local_o, u_if1.iter_o, u_if1.temp_o);
    end
    u_if1.body_done_i = 1'b1; u_if1.body_data_i = 8'hC3;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      u_if1.body_done_i = 1'b0;
      if (u_if1.done_o !== 1'b0 || u_if1.ready_o !== 1'b1 || u_if1.local_o !== 8'h0 || u_if1.iter_o !== 8'h0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL late_done: done=%b ready=%b local=%h iter=%h want 0/1/00/00",
                         u_if1.done_o, u_if1.ready_o, u_if1.local_o, u_if1.iter_o);
    end
  endtask

  task automatic test_ignored();
    int dc, p, sd, n; logic [7:0] ld; bit to;
    @(negedge clk);
    u_if1.body_done_i = 1'b1; u_if1.body_data_i = 8'h77;
    @(negedge clk);
    u_if1.body_done_i = 1'b0;
    checks++;
    if (u_if1.local_o !== 8'h0 || u_if1.iter_o !== 8'h0 || u_if1.ready_o !== 1'b1 || u_if1.temp_o !== 8'h0) begin
      errors++; $display("FAIL idle_done: local=%h iter=%h ready=%b temp=%h want 00/00/1/00",
                         u_if1.local_o, u_if1.iter_o, u_if1.ready_o, u_if1.temp_o);
    end
    n = model_iters(1, 4, 1, 8);
    run1(8'd1, 8'd4, 2, 1'b0, 8'h00, 1'b1, dc, p, sd, ld, to);
    checks++;
    if (to || p != n || dc != 2 + 2 * n + sd || u_if1.iter_o !== 8'(n) || u_if1.local_o !== ld) begin
      errors++; $display("FAIL busy_noise: pulses=%0d done_at=%0d iter=%0d local=%h want %0d/%0d/%0d/%h",
                         p, dc, u_if1.iter_o, u_if1.local_o, n, 2 + 2 * n + sd, n, ld);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    int dc, p, sd, n, ini, lim, md; logic [7:0] ld; bit to, nz;
    for (int k = 0; k < 25; k++) begin
      ini = $urandom_range(24, 0);
      lim = $urandom_range(24, 0);
      md  = $urandom_range(3, 1);
      nz  = 1'($urandom);
      n   = model_iters(ini, lim, 1, 8);
      run1(8'(ini), 8'(lim), md, 1'b0, 8'h00, nz, dc, p, sd, ld, to);
      checks++;
      if (to || p != n || dc != 2 + 2 * n + sd || u_if1.iter_o !== 8'(n) || u_if1.local_o !== (n == 0 ? 8'h0 : ld)) begin
        errors++; $display("FAIL rand_loop[%0d] init=%0d lim=%0d: pulses=%0d done_at=%0d iter=%0d local=%h want %0d/%0d/%0d/%h",
                           k, ini, lim, p, dc, u_if1.iter_o, u_if1.local_o, n, 2 + 2 * n + sd, n,
                           (n == 0 ? 8'h0 : ld));
      end
      @(negedge clk);
      checks++;
      if (u_if1.done_o !== 1'b0 || u_if1.ready_o !== 1'b1 || u_if1.temp_o !== 8'd1) begin
        errors++; $display("FAIL rand_after[%0d]: done=%b ready=%b temp=%h want 0/1/01",
                           k, u_if1.done_o, u_if1.ready_o, u_if1.temp_o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_zero_iter();
    test_scope();
    test_overflow();
    test_reset_mid();
    test_ignored();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
